// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the pipeline hazard controller: register-index width,
// the x0 constant, FSM state encoding and the pipeline control bundle.
package hazard_control_unit_pkg;

    localparam int unsigned RegIdxW  = 5;
    localparam int unsigned WaitCntW = 16;

    localparam logic [RegIdxW-1:0] RegX0 = '0;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StWait  = 2'd1,
        StError = 2'd2
    } hcu_state_e;

    // Pipeline register enables and NOP-injection controls, in one bundle.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic ex_mem_write;
        logic mem_wb_flush;
    } pipe_ctrl_t;

    // Normal flow: everything advances, nothing is squashed.
    function automatic pipe_ctrl_t ctrl_default();
        pipe_ctrl_t c;
        c.pc_write     = 1'b1;
        c.if_id_write  = 1'b1;
        c.if_id_flush  = 1'b0;
        c.id_ex_write  = 1'b1;
        c.id_ex_flush  = 1'b0;
        c.ex_mem_write = 1'b1;
        c.mem_wb_flush = 1'b0;
        return c;
    endfunction

    // Held in reset: nothing advances and every flushable stage loads a NOP.
    function automatic pipe_ctrl_t ctrl_reset();
        pipe_ctrl_t c;
        c.pc_write     = 1'b0;
        c.if_id_write  = 1'b0;
        c.if_id_flush  = 1'b1;
        c.id_ex_write  = 1'b0;
        c.id_ex_flush  = 1'b1;
        c.ex_mem_write = 1'b0;
        c.mem_wb_flush = 1'b1;
        return c;
    endfunction

    // Memory stall: front of the pipe holds, a bubble drains into WB.
    function automatic pipe_ctrl_t ctrl_freeze();
        pipe_ctrl_t c;
        c              = ctrl_default();
        c.pc_write     = 1'b0;
        c.if_id_write  = 1'b0;
        c.id_ex_write  = 1'b0;
        c.ex_mem_write = 1'b0;
        c.mem_wb_flush = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter: clears on reset, sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic at_max;

    assign at_max = &count;

    // Count qualified events, holding once the maximum is reached.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Decode-stage hazard controller: resolves memory wait, taken-branch and
// load-use hazards into PC / pipeline-register enables and flushes, watches
// data-memory wait length for a timeout and keeps saturating perf counters.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [RegIdxW-1:0] IF_ID_RS1,
    input  logic [RegIdxW-1:0] IF_ID_RS2,
    input  logic [RegIdxW-1:0] ID_EX_Rd,
    input  logic               ID_EX_MemRead,
    input  logic               EX_Branch_Taken,
    input  logic               EX_MEM_MemRead,
    input  logic               EX_MEM_MemWrite,
    input  logic               dmem_ready,
    output logic               PCWrite,
    output logic               IF_ID_Write,
    output logic               IF_ID_Flush,
    output logic               ID_EX_Write,
    output logic               ID_EX_Flush,
    output logic               EX_MEM_Write,
    output logic               MEM_WB_Flush,
    output logic               mem_error,
    output logic [CNT_W-1:0]   perf_load_use,
    output logic [CNT_W-1:0]   perf_branch,
    output logic [CNT_W-1:0]   perf_mem_wait
);

    localparam logic [WaitCntW-1:0] TimeoutCnt = WaitCntW'(MEM_TIMEOUT);

    hcu_state_e          state;
    logic [WaitCntW-1:0] wait_cnt;
    logic [WaitCntW-1:0] wait_next;

    logic       mem_wait;
    logic       load_use;
    logic       freeze;
    logic       branch_cycle;
    logic       load_use_cycle;
    pipe_ctrl_t ctrl;

    assign mem_wait = (EX_MEM_MemRead | EX_MEM_MemWrite) & ~dmem_ready;

    assign load_use = ID_EX_MemRead && (ID_EX_Rd != RegX0) &&
                      ((ID_EX_Rd == IF_ID_RS1) || (ID_EX_Rd == IF_ID_RS2));

    // ERROR keeps the pipe frozen even once memory stops reporting a wait.
    assign freeze = mem_wait || (state == StError);

    assign wait_next = wait_cnt + 1'b1;

    // Prioritised control decode: reset, then freeze, then branch, then load-use.
    always_comb begin
        ctrl           = ctrl_default();
        branch_cycle   = 1'b0;
        load_use_cycle = 1'b0;
        if (reset) begin
            ctrl = ctrl_reset();
        end else if (freeze) begin
            ctrl = ctrl_freeze();
        end else if (EX_Branch_Taken) begin
            // Squashing IF/ID also kills any load-use consumer sitting in ID.
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            branch_cycle     = 1'b1;
        end else if (load_use) begin
            ctrl.pc_write    = 1'b0;
            ctrl.if_id_write = 1'b0;
            ctrl.id_ex_flush = 1'b1;
            load_use_cycle   = 1'b1;
        end
    end

    assign PCWrite      = ctrl.pc_write;
    assign IF_ID_Write  = ctrl.if_id_write;
    assign IF_ID_Flush  = ctrl.if_id_flush;
    assign ID_EX_Write  = ctrl.id_ex_write;
    assign ID_EX_Flush  = ctrl.id_ex_flush;
    assign EX_MEM_Write = ctrl.ex_mem_write;
    assign MEM_WB_Flush = ctrl.mem_wb_flush;

    // Memory-wait tracker: counts consecutive wait cycles, latches ERROR on timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StRun;
            wait_cnt  <= '0;
            mem_error <= 1'b0;
        end else begin
            unique case (state)
                StRun: begin
                    if (mem_wait) begin
                        // wait_cnt is zero in RUN, so wait_next is 1 here.
                        wait_cnt <= wait_next;
                        if (wait_next == TimeoutCnt) begin
                            state     <= StError;
                            mem_error <= 1'b1;
                        end else begin
                            state <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (mem_wait) begin
                        wait_cnt <= wait_next;
                        if (wait_next == TimeoutCnt) begin
                            state     <= StError;
                            mem_error <= 1'b1;
                        end
                    end else begin
                        state    <= StRun;
                        wait_cnt <= '0;
                    end
                end
                StError: begin
                    mem_error <= 1'b1;
                end
                default: begin
                    state     <= StRun;
                    wait_cnt  <= '0;
                    mem_error <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_cnt_load_use (
        .clk  (clk),
        .reset(reset),
        .inc  (load_use_cycle),
        .count(perf_load_use)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_cnt_branch (
        .clk  (clk),
        .reset(reset),
        .inc  (branch_cycle),
        .count(perf_branch)
    );

    // Every wait cycle is counted, including those that occur while in ERROR.
    sat_counter #(
        .W(CNT_W)
    ) u_cnt_mem_wait (
        .clk  (clk),
        .reset(reset),
        .inc  (mem_wait & ~reset),
        .count(perf_mem_wait)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: a stimulus process drives inputs
// and pushes model predictions; a monitor pops and compares each cycle.
module tb_hazard_control_unit;

    localparam int unsigned CNT_W       = 3;
    localparam int unsigned MEM_TIMEOUT = 5;
    localparam int          CntMax      = (1 << CNT_W) - 1;

    // Control vector order: PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
    // ID_EX_Flush, EX_MEM_Write, MEM_WB_Flush.
    localparam logic [6:0] CtlReset  = 7'b0010101;
    localparam logic [6:0] CtlFreeze = 7'b0000001;
    localparam logic [6:0] CtlBranch = 7'b1111110;
    localparam logic [6:0] CtlLdUse  = 7'b0001110;
    localparam logic [6:0] CtlNormal = 7'b1101010;

    logic             clk;
    logic             reset;
    logic [4:0]       IF_ID_RS1, IF_ID_RS2, ID_EX_Rd;
    logic             ID_EX_MemRead, EX_Branch_Taken, EX_MEM_MemRead, EX_MEM_MemWrite;
    logic             dmem_ready;
    logic             PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush;
    logic             EX_MEM_Write, MEM_WB_Flush, mem_error;
    logic [CNT_W-1:0] perf_load_use, perf_branch, perf_mem_wait;

    hazard_control_unit #(
        .CNT_W      (CNT_W),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .IF_ID_RS1      (IF_ID_RS1),
        .IF_ID_RS2      (IF_ID_RS2),
        .ID_EX_Rd       (ID_EX_Rd),
        .ID_EX_MemRead  (ID_EX_MemRead),
        .EX_Branch_Taken(EX_Branch_Taken),
        .EX_MEM_MemRead (EX_MEM_MemRead),
        .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .dmem_ready     (dmem_ready),
        .PCWrite        (PCWrite),
        .IF_ID_Write    (IF_ID_Write),
        .IF_ID_Flush    (IF_ID_Flush),
        .ID_EX_Write    (ID_EX_Write),
        .ID_EX_Flush    (ID_EX_Flush),
        .EX_MEM_Write   (EX_MEM_Write),
        .MEM_WB_Flush   (MEM_WB_Flush),
        .mem_error      (mem_error),
        .perf_load_use  (perf_load_use),
        .perf_branch    (perf_branch),
        .perf_mem_wait  (perf_mem_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]       ctrl;
        logic             err;
        logic [CNT_W-1:0] lu;
        logic [CNT_W-1:0] br;
        logic [CNT_W-1:0] mw;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: sticky error, length of current wait run, plain counters.
    bit m_err = 1'b0;
    int m_run = 0;
    int m_lu  = 0;
    int m_br  = 0;
    int m_mw  = 0;

    function automatic int sat_inc(input int v);
        return (v < CntMax) ? v + 1 : v;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // One cycle of stimulus: drive after the edge, predict, advance the model.
    task automatic step(input bit rst, input int rs1, input int rs2, input int rd,
                        input bit idmr, input bit br, input bit mr, input bit mwr,
                        input bit rdy);
        exp_t e;
        bit   memw;
        bit   lu;
        bit   frz;
        @(posedge clk);
        #1;
        reset           = rst;
        IF_ID_RS1       = 5'(rs1);
        IF_ID_RS2       = 5'(rs2);
        ID_EX_Rd        = 5'(rd);
        ID_EX_MemRead   = idmr;
        EX_Branch_Taken = br;
        EX_MEM_MemRead  = mr;
        EX_MEM_MemWrite = mwr;
        dmem_ready      = rdy;

        memw = (mr || mwr) && !rdy;
        lu   = idmr && (rd != 0) && (rd == rs1 || rd == rs2);
        frz  = memw || m_err;

        e.err = m_err;
        e.lu  = CNT_W'(m_lu);
        e.br  = CNT_W'(m_br);
        e.mw  = CNT_W'(m_mw);
        if (rst)      e.ctrl = CtlReset;
        else if (frz) e.ctrl = CtlFreeze;
        else if (br)  e.ctrl = CtlBranch;
        else if (lu)  e.ctrl = CtlLdUse;
        else          e.ctrl = CtlNormal;
        exp_q.push_back(e);

        if (rst) begin
            m_err = 1'b0;
            m_run = 0;
            m_lu  = 0;
            m_br  = 0;
            m_mw  = 0;
        end else begin
            if (memw) m_mw = sat_inc(m_mw);
            if (!frz && br) m_br = sat_inc(m_br);
            else if (!frz && lu) m_lu = sat_inc(m_lu);
            if (!m_err) begin
                if (memw) begin
                    m_run++;
                    if (m_run >= MEM_TIMEOUT) m_err = 1'b1;
                end else begin
                    m_run = 0;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Monitor: compare the DUT against the oldest prediction on each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ctrl", int'({PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
                                    ID_EX_Flush, EX_MEM_Write, MEM_WB_Flush}),
                      int'(e.ctrl));
                check("mem_error", int'(mem_error), int'(e.err));
                check("perf_load_use", int'(perf_load_use), int'(e.lu));
                check("perf_branch", int'(perf_branch), int'(e.br));
                check("perf_mem_wait", int'(perf_mem_wait), int'(e.mw));
            end
        end
    end

    initial begin
        int stall_len;
        reset           = 1'b1;
        IF_ID_RS1       = '0;
        IF_ID_RS2       = '0;
        ID_EX_Rd        = '0;
        ID_EX_MemRead   = 1'b0;
        EX_Branch_Taken = 1'b0;
        EX_MEM_MemRead  = 1'b0;
        EX_MEM_MemWrite = 1'b0;
        dmem_ready      = 1'b1;

        // Reset held, then released.
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);

        // Load-use on rs2, then the same with rd = x0 (no stall).
        step(0, 3, 5, 5, 1, 0, 0, 0, 1);
        idle(1);
        step(0, 0, 0, 0, 1, 0, 0, 0, 1);
        step(0, 7, 2, 7, 1, 0, 0, 0, 1);

        // Branch coinciding with a load-use match.
        step(0, 9, 4, 9, 1, 1, 0, 0, 1);
        idle(1);

        // Three wait cycles on a load, then ready.
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle(1);

        // Branch held through a store wait is taken when memory responds.
        step(0, 0, 0, 0, 0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0, 1, 1);
        idle(1);

        // Timeout: stay frozen after ready returns, until reset.
        for (int i = 0; i < MEM_TIMEOUT + 2; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0, 1);
        step(0, 1, 0, 1, 1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);

        // Counter saturation on back-to-back branches.
        for (int i = 0; i < CntMax + 3; i++) step(0, 0, 0, 0, 0, 1, 0, 0, 1);
        idle(1);

        // Reset arriving in the second wait cycle.
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);

        // Randomised traffic with occasional long memory stalls and resets.
        stall_len = 0;
        for (int i = 0; i < 3000; i++) begin
            bit rst, idmr, br, mr, mwr, rdy;
            int rs1, rs2, rd;
            rst  = ($urandom_range(0, 149) == 0);
            rs1  = int'($urandom_range(0, 3));
            rs2  = int'($urandom_range(0, 3));
            rd   = int'($urandom_range(0, 3));
            idmr = ($urandom_range(0, 1) == 1);
            br   = ($urandom_range(0, 3) == 0);
            mr   = ($urandom_range(0, 3) == 0);
            mwr  = ($urandom_range(0, 4) == 0);
            rdy  = ($urandom_range(0, 3) != 0);
            if (stall_len == 0 && $urandom_range(0, 59) == 0) begin
                stall_len = int'($urandom_range(1, MEM_TIMEOUT + 2));
            end
            if (stall_len > 0) begin
                mr  = 1'b1;
                rdy = 1'b0;
                stall_len--;
            end
            step(rst, rs1, rs2, rd, idmr, br, mr, mwr, rdy);
        end

        // Let the monitor drain, with a bounded wait.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        check("scoreboard_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
